// File: rtl/serial_acc_sequencer.sv
// Bit-serial 4-bit add/subtract accumulator sharing one full adder over four cycles.
// state  | meaning
// IDLE   | sample cmd every edge; load commits at once, add/sub preload the shifter
// SHIFT  | one result bit per edge through the shared full adder, LSB first
// DONE   | one-cycle done pulse; cmd ignored, back to IDLE on the next edge
module serial_acc_sequencer #(
    parameter bit SUB_EN = 1'b1
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_ADD  = 2'b01;
    localparam logic [1:0] CMD_SUB  = 2'b10;
    localparam logic [1:0] CMD_LOAD = 2'b11;

    logic       clk_sys;
    logic       rst_n;
    logic [1:0] cmd;
    logic [3:0] opnd_b;

    assign clk_sys = io_in[7];
    assign rst_n   = io_in[6];
    assign cmd     = io_in[5:4];
    assign opnd_b  = io_in[3:0];

    state_t     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic [3:0] w_q, w_d;
    logic [3:0] bsh_q, bsh_d;
    logic       c_q, c_d;
    logic [1:0] cnt_q, cnt_d;

    logic sum_bit;
    logic maj_bit;

    assign sum_bit = w_q[0] ^ bsh_q[0] ^ c_q;
    assign maj_bit = (w_q[0] & bsh_q[0]) | (w_q[0] & c_q) | (bsh_q[0] & c_q);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 4'd0;
            carry_q <= 1'b0;
            w_q     <= 4'd0;
            bsh_q   <= 4'd0;
            c_q     <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            w_q     <= w_d;
            bsh_q   <= bsh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        w_d     = w_q;
        bsh_d   = bsh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                case (cmd)
                    CMD_ADD: begin
                        w_d     = acc_q;
                        bsh_d   = opnd_b;
                        c_d     = 1'b0;
                        cnt_d   = 2'd0;
                        state_d = ST_SHIFT;
                    end
                    CMD_SUB: begin
                        // Subtract as acc + ~B + 1; carry-out 1 means no borrow.
                        if (SUB_EN) begin
                            w_d     = acc_q;
                            bsh_d   = ~opnd_b;
                            c_d     = 1'b1;
                            cnt_d   = 2'd0;
                            state_d = ST_SHIFT;
                        end
                    end
                    CMD_LOAD: begin
                        acc_d   = opnd_b;
                        carry_d = 1'b0;
                        state_d = ST_DONE;
                    end
                    CMD_NOP: ;
                    default: ;
                endcase
            end
            ST_SHIFT: begin
                w_d   = {sum_bit, w_q[3:1]};
                bsh_d = {1'b0, bsh_q[3:1]};
                c_d   = maj_bit;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    acc_d   = {sum_bit, w_q[3:1]};
                    carry_d = maj_bit;
                    state_d = ST_DONE;
                end
            end
            // A held cmd is next seen on the first IDLE edge, one edge after DONE.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign io_out = {(acc_q == 4'd0), (state_q == ST_DONE), (state_q == ST_SHIFT), carry_q, acc_q};

endmodule

// File: tb/tb_serial_acc_sequencer.sv
// Bench for serial_acc_sequencer: vector table plus scoreboard of commit words
// checked whenever done pulses, and hand sequences for reset, hold and ignore cases.
module tb_serial_acc_sequencer;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n  = 1'b1;
    logic [1:0] cmd    = 2'b00;
    logic [3:0] b      = 4'd0;
    logic [1:0] cmd2   = 2'b00;
    logic [3:0] b2     = 4'd0;
    logic [7:0] io_in, io_out, io_in2, io_out2;

    assign io_in  = {clk, rst_n, cmd, b};
    assign io_in2 = {clk, rst_n, cmd2, b2};

    serial_acc_sequencer #(.SUB_EN(1'b1)) u_dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    serial_acc_sequencer #(.SUB_EN(1'b0)) u_nosub (
        .io_in (io_in2),
        .io_out(io_out2)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] done_word(input logic [3:0] a, input logic c);
        return {(a == 4'd0), 1'b1, 1'b0, c, a};
    endfunction

    // Returns {carry, acc} after applying cmd to acc a.
    function automatic logic [4:0] model(input logic [3:0] a, input logic [1:0] c, input logic [3:0] bb);
        case (c)
            2'b01:   return {1'b0, a} + {1'b0, bb};
            2'b10:   return {(a >= bb), 4'(a - bb)};
            2'b11:   return {1'b0, bb};
            default: return {1'b0, a};
        endcase
    endfunction

    logic [7:0] sb_q[$];
    logic [7:0] mon_exp;

    always begin
        @(posedge clk);
        #1;
        if (io_out[6] === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", {7'b0, io_out[6]}, 8'h00);
            end else begin
                mon_exp = sb_q.pop_front();
                check("commit", io_out, mon_exp);
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] c, input logic [3:0] bb,
                          input logic [3:0] exp_acc, input logic exp_carry);
        logic [3:0] acc_before;
        int nbusy;
        int n;
        logic held;
        acc_before = io_out[3:0];
        nbusy = 0;
        n = 0;
        held = 1'b1;
        sb_q.push_back(done_word(exp_acc, exp_carry));
        cmd = c;
        b = bb;
        tick();
        cmd = 2'b00;
        while (io_out[6] !== 1'b1 && n < 12) begin
            if (io_out[5] === 1'b1) begin
                nbusy++;
                if (io_out[3:0] !== acc_before) held = 1'b0;
            end
            tick();
            n++;
        end
        if (io_out[6] !== 1'b1) check({name, "_timeout"}, {7'b0, io_out[6]}, 8'h01);
        check({name, "_busy_cycles"}, 8'(nbusy), (c == 2'b11) ? 8'd0 : 8'd4);
        check({name, "_acc_hold"}, {7'b0, held}, 8'h01);
        tick();
        check({name, "_idle"}, {6'b0, io_out[6:5]}, 8'h00);
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [3:0] b;
        logic [3:0] exp_acc;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] acc_m;
        logic [4:0] r;
        logic [1:0] rc;
        logic [3:0] rb;
        int done_cyc[3];
        int ndone;
        int n;

        vecs[0]  = '{2'b11, 4'd5,  4'd5,  1'b0};
        vecs[1]  = '{2'b01, 4'd3,  4'd8,  1'b0};
        vecs[2]  = '{2'b01, 4'd9,  4'd1,  1'b1};
        vecs[3]  = '{2'b11, 4'd5,  4'd5,  1'b0};
        vecs[4]  = '{2'b10, 4'd5,  4'd0,  1'b1};
        vecs[5]  = '{2'b11, 4'd3,  4'd3,  1'b0};
        vecs[6]  = '{2'b10, 4'd5,  4'd14, 1'b0};
        vecs[7]  = '{2'b01, 4'd15, 4'd13, 1'b1};
        vecs[8]  = '{2'b10, 4'd0,  4'd13, 1'b1};
        vecs[9]  = '{2'b01, 4'd0,  4'd13, 1'b0};
        vecs[10] = '{2'b11, 4'd0,  4'd0,  1'b0};
        vecs[11] = '{2'b10, 4'd1,  4'd15, 1'b0};

        // Reset with the clock stopped.
        #2 rst_n = 1'b0;
        #1 check("reset_async", io_out, 8'h80);
        check("reset_async_nosub", io_out2, 8'h80);
        #2 rst_n = 1'b1;
        #1 check("reset_release", io_out, 8'h80);
        clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nop_after_reset", io_out, 8'h80);
        end

        // SUB_EN=0 instance: subtract behaves as nop.
        cmd2 = 2'b11;
        b2 = 4'd6;
        tick();
        check("nosub_load_done", io_out2, 8'h46);
        cmd2 = 2'b00;
        tick();
        check("nosub_load_idle", io_out2, 8'h06);
        cmd2 = 2'b10;
        b2 = 4'd2;
        tick();
        check("nosub_sub_ignored", io_out2, 8'h06);
        tick();
        check("nosub_sub_ignored2", io_out2, 8'h06);
        cmd2 = 2'b00;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].b, vecs[i].exp_acc, vecs[i].exp_carry);
        end
        acc_m = vecs[11].exp_acc;

        for (int i = 0; i < 8; i++) begin
            rc = 2'($urandom_range(1, 3));
            rb = 4'($urandom);
            r = model(acc_m, rc, rb);
            run_op($sformatf("rand%0d", i), rc, rb, r[3:0], r[4]);
            acc_m = r[3:0];
        end

        // Load issued during SHIFT and DONE must be ignored.
        r = model(acc_m, 2'b01, 4'd2);
        sb_q.push_back(done_word(r[3:0], r[4]));
        cmd = 2'b01;
        b = 4'd2;
        tick();
        cmd = 2'b11;
        b = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        check("ign_done_pulse", {6'b0, io_out[6:5]}, 8'h02);
        tick();
        cmd = 2'b00;
        check("ign_after_done", io_out, {(r[3:0] == 4'd0), 2'b00, r[4], r[3:0]});
        tick();
        check("ign_still_idle", io_out, {(r[3:0] == 4'd0), 2'b00, r[4], r[3:0]});
        acc_m = r[3:0];

        // Held add of 1 from zero.
        run_op("hold_load", 2'b11, 4'd0, 4'd0, 1'b0);
        sb_q.push_back(done_word(4'd1, 1'b0));
        sb_q.push_back(done_word(4'd2, 1'b0));
        sb_q.push_back(done_word(4'd3, 1'b0));
        cmd = 2'b01;
        b = 4'd1;
        ndone = 0;
        n = 0;
        while (ndone < 3 && n < 40) begin
            tick();
            n++;
            if (io_out[6] === 1'b1) begin
                done_cyc[ndone] = cyc;
                ndone++;
            end
        end
        cmd = 2'b00;
        check("hold_commits", 8'(ndone), 8'd3);
        if (ndone == 3) begin
            check("hold_gap1", 8'(done_cyc[1] - done_cyc[0]), 8'd6);
            check("hold_gap2", 8'(done_cyc[2] - done_cyc[1]), 8'd6);
        end
        tick();
        check("hold_final", io_out, 8'h03);

        // Reset in the middle of an add, at cnt=2.
        cmd = 2'b01;
        b = 4'd4;
        tick();
        cmd = 2'b00;
        tick();
        tick();
        check("midop_busy", {7'b0, io_out[5]}, 8'h01);
        #2 rst_n = 1'b0;
        #1 check("midop_reset", io_out, 8'h80);
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_nop", io_out, 8'h80);
        run_op("post_reset_add", 2'b01, 4'd7, 4'd7, 1'b0);
        check("post_reset_acc", io_out, 8'h07);

        tick();
        check("scoreboard_empty", 8'(sb_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
